// File: rtl/enemy_sprite_draw_pkg.sv
// Shared types and constants for the enemy sprite plotting stage.
package enemy_sprite_draw_pkg;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int CNT_W    = 6;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK    = 3'b000;
  localparam logic [2:0] CALM_DEF = 3'b010;
  localparam logic [2:0] ATK_DEF  = 3'b100;

  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_DRAW, S_KILL, S_DEAD} state_t;
endpackage

// File: rtl/enemy_sprite_draw_box_scanner.sv
// Raster scan of a WIDTH x HEIGHT box, one pixel per step, row-major.
module box_scanner
  import enemy_sprite_draw_pkg::*;
#(
  parameter int WIDTH  = 20,
  parameter int HEIGHT = 30
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic           step,
  input  logic [X_W-1:0] base_x,
  input  logic [Y_W-1:0] base_y,
  output logic [X_W-1:0] px,
  output logic [Y_W-1:0] py,
  output logic           last
);
  localparam logic [CNT_W-1:0] CX_MAX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CY_MAX = CNT_W'(HEIGHT - 1);

  logic [CNT_W-1:0] cx, cy;

  assign last = step && (cx == CX_MAX) && (cy == CY_MAX);
  assign px   = base_x + X_W'(cx);
  assign py   = base_y + Y_W'(cy);

  always_ff @(posedge clock) begin
    if (!reset_n || start) begin
      cx <= '0;
      cy <= '0;
    end else if (step) begin
      if (cx == CX_MAX) begin
        cx <= '0;
        cy <= (cy == CY_MAX) ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/enemy_sprite_draw.sv
// Erase-then-redraw sprite plotter feeding the VGA adapter one pixel per clock.
module enemy_sprite_draw
  import enemy_sprite_draw_pkg::*;
#(
  parameter int         WIDTH       = 20,
  parameter int         HEIGHT      = 30,
  parameter logic [2:0] CALM_COLOUR = CALM_DEF,
  parameter logic [2:0] ATK_COLOUR  = ATK_DEF
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           move,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  input  logic           attacking,
  input  logic           dead,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     colour,
  output logic           plot,
  output logic           busy
);
  state_t state, state_n;

  logic [X_W-1:0] old_x, new_x, draw_x, base_x, px;
  logic [Y_W-1:0] old_y, new_y, draw_y, base_y, py;
  logic [2:0]     new_col, draw_col, in_col;
  logic           old_valid, pending;
  logic           scanning, last, dispatch, take_move;

  assign in_col    = attacking ? ATK_COLOUR : CALM_COLOUR;
  assign scanning  = (state == S_ERASE) || (state == S_KILL) || (state == S_DRAW);
  assign take_move = move && (scanning || (state == S_IDLE && !dead));

  // A queued move at the end of a draw skips S_IDLE so the redraw follows back-to-back.
  always_comb begin
    state_n  = state;
    dispatch = 1'b0;
    case (state)
      S_IDLE: begin
        if (dead) begin
          state_n = old_valid ? S_KILL : S_DEAD;
        end else if (move || pending) begin
          dispatch = 1'b1;
          state_n  = old_valid ? S_ERASE : S_DRAW;
        end
      end
      S_ERASE: if (last) state_n = S_DRAW;
      S_KILL:  if (last) state_n = S_DEAD;
      S_DRAW: begin
        if (last) begin
          if ((move || pending) && !dead) begin
            dispatch = 1'b1;
            state_n  = S_ERASE;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = state;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      old_x     <= '0;
      old_y     <= '0;
      old_valid <= 1'b0;
      new_x     <= '0;
      new_y     <= '0;
      new_col   <= BLACK;
      draw_x    <= '0;
      draw_y    <= '0;
      draw_col  <= BLACK;
      pending   <= 1'b0;
    end else begin
      state <= state_n;
      if (take_move) begin
        new_x   <= x_in;
        new_y   <= y_in;
        new_col <= in_col;
      end
      // The active draw target is held apart so late moves cannot disturb a scan in progress.
      if (dispatch) begin
        pending  <= 1'b0;
        draw_x   <= move ? x_in   : new_x;
        draw_y   <= move ? y_in   : new_y;
        draw_col <= move ? in_col : new_col;
      end else if (take_move && scanning) begin
        pending <= 1'b1;
      end
      if (state == S_DRAW && last) begin
        old_x     <= draw_x;
        old_y     <= draw_y;
        old_valid <= 1'b1;
      end
      if (state == S_KILL && last) old_valid <= 1'b0;
    end
  end

  assign base_x = (state == S_DRAW) ? draw_x : old_x;
  assign base_y = (state == S_DRAW) ? draw_y : old_y;

  box_scanner #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_scan (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (state_n != state),
    .step    (scanning),
    .base_x  (base_x),
    .base_y  (base_y),
    .px      (px),
    .py      (py),
    .last    (last)
  );

  assign plot   = scanning;
  assign busy   = scanning;
  assign vga_x  = scanning ? px : '0;
  assign vga_y  = scanning ? py : '0;
  assign colour = (state == S_DRAW) ? draw_col : BLACK;
endmodule

// File: tb/tb_enemy_sprite_draw.sv
// Bench for enemy_sprite_draw (4x2 sprite): directed table, corner sequences, random vs pixel-queue model.
module tb_enemy_sprite_draw;
  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       move = 1'b0, attacking = 1'b0, dead = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot, busy;

  int checks = 0, failures = 0;
  bit chk_en = 0;

  typedef struct {logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;
  typedef struct {logic [7:0] x; logic [6:0] y; logic atk; int busy_cyc; pix_t first; pix_t last;} vec_t;

  pix_t exp_q[$];
  pix_t act_log[$];

  enemy_sprite_draw #(.WIDTH(4), .HEIGHT(2)) dut (
    .clock(clock), .reset_n(reset_n), .move(move), .x_in(x_in), .y_in(y_in),
    .attacking(attacking), .dead(dead), .vga_x(vga_x), .vga_y(vga_y),
    .colour(colour), .plot(plot), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every job is a list of pixels; the queue being non-empty is "busy".
  logic [7:0] m_old_x, m_tgt_x, m_px;
  logic [6:0] m_old_y, m_tgt_y, m_py;
  logic [2:0] m_pc;
  bit m_old_valid, m_pend, m_kill, m_dead;

  function automatic logic [2:0] col_of(input logic atk);
    return atk ? 3'b100 : 3'b010;
  endfunction

  task automatic push_box(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] c);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) begin
        pix_t p;
        p.x = bx + 8'(k);
        p.y = by + 7'(r);
        p.c = c;
        exp_q.push_back(p);
      end
  endtask

  task automatic start_job(input logic [7:0] nx, input logic [6:0] ny, input logic [2:0] c);
    if (m_old_valid) push_box(m_old_x, m_old_y, 3'b000);
    push_box(nx, ny, c);
    m_tgt_x = nx;
    m_tgt_y = ny;
  endtask

  always @(posedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      m_old_valid = 0; m_pend = 0; m_kill = 0; m_dead = 0;
      m_old_x = 0; m_old_y = 0;
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      if (move) begin m_pend = 1; m_px = x_in; m_py = y_in; m_pc = col_of(attacking); end
      if (exp_q.size() == 0) begin
        if (m_kill) begin
          m_kill = 0; m_old_valid = 0; m_dead = 1;
        end else begin
          m_old_x = m_tgt_x; m_old_y = m_tgt_y; m_old_valid = 1;
          if (m_pend && !dead) begin m_pend = 0; start_job(m_px, m_py, m_pc); end
        end
      end
    end else if (!m_dead) begin
      if (dead) begin
        if (m_old_valid) begin push_box(m_old_x, m_old_y, 3'b000); m_kill = 1; end
        else m_dead = 1;
      end else if (move) begin
        m_pend = 0; start_job(x_in, y_in, col_of(attacking));
      end else if (m_pend) begin
        m_pend = 0; start_job(m_px, m_py, m_pc);
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("plot", plot, exp_q.size() > 0);
      check("busy", busy, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        check("vga_x", vga_x, exp_q[0].x);
        check("vga_y", vga_y, exp_q[0].y);
        check("colour", colour, exp_q[0].c);
      end
    end
    if (plot === 1'b1) act_log.push_back('{vga_x, vga_y, colour});
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic apply_reset();
    reset_n = 0; move = 0; dead = 0;
    tick(2);
    reset_n = 1;
  endtask

  task automatic do_move(input logic [7:0] x, input logic [6:0] y, input logic atk);
    move = 1; x_in = x; y_in = y; attacking = atk;
    tick(1);
    move = 0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 300) begin tick(1); n++; end
    if (n >= 300) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic check_pix(input string name, input pix_t a, input pix_t e);
    check({name, "_x"}, a.x, e.x);
    check({name, "_y"}, a.y, e.y);
    check({name, "_c"}, a.c, e.c);
  endtask

  initial begin
    vec_t tbl[4];
    int n;
    bit saw100;

    tbl[0] = '{8'd20,  7'd8,   1'b0, 8,  '{8'd20,  7'd8,   3'b010}, '{8'd23,  7'd9,   3'b010}};
    tbl[1] = '{8'd60,  7'd8,   1'b1, 16, '{8'd20,  7'd8,   3'b000}, '{8'd63,  7'd9,   3'b100}};
    tbl[2] = '{8'd156, 7'd118, 1'b0, 16, '{8'd60,  7'd8,   3'b000}, '{8'd159, 7'd119, 3'b010}};
    tbl[3] = '{8'd0,   7'd0,   1'b1, 16, '{8'd156, 7'd118, 3'b000}, '{8'd3,   7'd1,   3'b100}};

    apply_reset();
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_colour", colour, 0);
    chk_en = 1;

    foreach (tbl[i]) begin
      act_log.delete();
      do_move(tbl[i].x, tbl[i].y, tbl[i].atk);
      wait_idle(n);
      check("tbl_busy_cycles", n, tbl[i].busy_cyc);
      check("tbl_plots", act_log.size(), tbl[i].busy_cyc);
      if (act_log.size() > 0) begin
        check_pix("tbl_first", act_log[0], tbl[i].first);
        check_pix("tbl_last", act_log[act_log.size()-1], tbl[i].last);
      end
    end

    // Two moves queued during a busy sequence: only the last survives.
    act_log.delete();
    do_move(8'd40, 7'd8, 1'b0);
    tick(3);
    do_move(8'd100, 7'd8, 1'b0);
    tick(2);
    do_move(8'd20, 7'd8, 1'b0);
    wait_idle(n);
    check("coalesce_plots", act_log.size(), 32);
    saw100 = 0;
    foreach (act_log[i]) if (act_log[i].x >= 100 && act_log[i].x <= 103) saw100 = 1;
    check("coalesce_no_x100", saw100, 0);
    if (act_log.size() > 0) check_pix("coalesce_last", act_log[act_log.size()-1], '{8'd20 + 8'd3, 7'd9, 3'b010});

    // Dead after a draw: kill erase, then permanently quiet.
    do_move(8'd60, 7'd8, 1'b1);
    wait_idle(n);
    act_log.delete();
    dead = 1;
    tick(1);
    wait_idle(n);
    check("kill_cycles", n, 8);
    check("kill_plots", act_log.size(), 8);
    if (act_log.size() == 8) begin
      check_pix("kill_first", act_log[0], '{8'd60, 7'd8, 3'b000});
      check_pix("kill_last", act_log[7], '{8'd63, 7'd9, 3'b000});
    end
    act_log.delete();
    do_move(8'd10, 7'd10, 1'b0);
    tick(5);
    dead = 0;
    do_move(8'd30, 7'd30, 1'b0);
    tick(5);
    check("dead_ignores_move", act_log.size(), 0);

    // Reset during pixel 3 of a draw, then a fresh draw with no erase.
    apply_reset();
    do_move(8'd20, 7'd8, 1'b0);
    tick(3);
    reset_n = 0;
    tick(1);
    check("midrst_plot", plot, 0);
    check("midrst_busy", busy, 0);
    reset_n = 1;
    act_log.delete();
    do_move(8'd60, 7'd8, 1'b1);
    wait_idle(n);
    check("post_rst_cycles", n, 8);
    if (act_log.size() > 0) check_pix("post_rst_first", act_log[0], '{8'd60, 7'd8, 3'b100});

    // Move and dead together with nothing drawn.
    apply_reset();
    act_log.delete();
    dead = 1; move = 1; x_in = 8'd30; y_in = 7'd5;
    tick(1);
    move = 0;
    tick(4);
    check("movedead_busy", busy, 0);
    dead = 0;
    do_move(8'd30, 7'd5, 1'b0);
    tick(4);
    check("movedead_plots", act_log.size(), 0);

    // Random traffic against the pixel-queue model.
    for (int r = 0; r < 3; r++) begin
      apply_reset();
      for (int c = 0; c < 500; c++) begin
        move = ($urandom % 6) == 0;
        x_in = 8'($urandom_range(0, 156));
        y_in = 7'($urandom_range(0, 118));
        attacking = 1'($urandom % 2);
        dead = ($urandom % 400) == 0;
        tick(1);
      end
      move = 0; dead = 0;
      tick(40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
